// File: rtl/load_scoreboard_if.sv
// load_scoreboard_if
//   Bundles the issue, memory-response, writeback and hazard signals that
//   connect the pipeline to the load scoreboard.
//   master : pipeline side (drives issue/response/ID operands, sees results)
//   slave  : scoreboard side
//   Signals:
//     issue_valid / issue_rd / issue_ready  load leaving EX toward memory
//     mem_resp_valid                        data returned for oldest load
//     wb_valid / wb_rd                      register-file writeback port
//     if_id_rs1 / if_id_rs2 / stall         ID-stage operand hazard check
//     pending_count / error                 status

interface load_scoreboard_if #(
  parameter int DEPTH = 4,
  parameter int REG_W = 5
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic             issue_ready;
  logic             mem_resp_valid;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic [REG_W-1:0] if_id_rs1;
  logic [REG_W-1:0] if_id_rs2;
  logic             stall;
  logic [CNT_W-1:0] pending_count;
  logic             error;

  modport master (
    output issue_valid, issue_rd, mem_resp_valid, if_id_rs1, if_id_rs2,
    input  issue_ready, wb_valid, wb_rd, stall, pending_count, error
  );

  modport slave (
    input  issue_valid, issue_rd, mem_resp_valid, if_id_rs1, if_id_rs2,
    output issue_ready, wb_valid, wb_rd, stall, pending_count, error
  );
endinterface

// File: rtl/load_scoreboard.sv
// load_scoreboard
//   In-order tag FIFO of destination registers for loads that have left EX
//   but not yet written back. Loads are pushed at issue and popped at memory
//   response; each pop drives the register-file writeback address. ID-stage
//   operands that name a still-outstanding destination raise stall.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     sb     load_scoreboard_if.slave (issue, response, writeback, hazard,
//            pending_count, sticky error)

module load_scoreboard #(
  parameter int DEPTH = 4,
  parameter int REG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  load_scoreboard_if.slave    sb
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_valid;
  logic [REG_W-1:0] r_rd [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_error;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;
  logic [REG_W-1:0] w_head_rd;
  logic             w_busy_rs1;
  logic             w_busy_rs2;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Full blocks issue even when a pop happens in the same cycle.
  assign w_push    = sb.issue_valid && !w_full;
  assign w_pop     = sb.mem_resp_valid && !w_empty;
  assign w_err_set = (sb.mem_resp_valid && w_empty) || (sb.issue_valid && w_full);
  assign w_head_rd = r_rd[r_rd_ptr];

  // The head entry being popped this cycle is written back through a
  // write-first register file, so it no longer counts as busy.
  always_comb begin
    w_busy_rs1 = 1'b0;
    w_busy_rs2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && !(w_pop && (PTR_W'(i) == r_rd_ptr))) begin
        if (r_rd[i] == sb.if_id_rs1) w_busy_rs1 = 1'b1;
        if (r_rd[i] == sb.if_id_rs2) w_busy_rs2 = 1'b1;
      end
    end
    if (sb.if_id_rs1 == '0) w_busy_rs1 = 1'b0;
    if (sb.if_id_rs2 == '0) w_busy_rs2 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      for (int i = 0; i < DEPTH; i++) r_rd[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      // Push and pop never target the same slot: that would need the FIFO
      // to be both full (no push) and empty (no pop).
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd[r_rd_ptr]    <= '0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_rd[r_wr_ptr]    <= sb.issue_rd;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (w_err_set) r_error <= 1'b1;
    end
  end

  assign sb.issue_ready   = !w_full;
  assign sb.wb_rd         = w_head_rd;
  // Loads to x0 occupy a slot and pop normally but never write back.
  assign sb.wb_valid      = w_pop && (w_head_rd != '0);
  assign sb.stall         = w_busy_rs1 || w_busy_rs2;
  assign sb.pending_count = r_count;
  assign sb.error         = r_error;

endmodule
